// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_if
// Description : Update channel (valid/ready) carrying a 24-bit hex value and
//               a 6-bit decimal-point mask into the display scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
    logic [23:0] upd_data;
    logic [5:0]  upd_dp;
    logic        upd_valid;
    logic        upd_ready;

    modport master (output upd_data, output upd_dp, output upd_valid, input  upd_ready);
    modport slave  (input  upd_data, input  upd_dp, input  upd_valid, output upd_ready);
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : 6-digit time-multiplexed seven-segment scan controller with a
//               double-buffered, tear-free update path. Optional macro
//               LEADING_ZERO_BLANK_EN blanks leading zero digits 5..1.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCAN_FREQ = 1_000,
    parameter int BLANK_CYC = 500
) (
    input  wire logic       sys_clk,
    input  wire logic       sys_rst,
    input  wire logic       en,
    seg_scan_ctrl_if.slave  upd,
    output logic            frame_start,
    output logic [5:0]      sel,
    output logic [7:0]      seg
);

    localparam int c_DWELL = CLK_FREQ / SCAN_FREQ;
    localparam int c_CNT_W = (c_DWELL > 1) ? $clog2(c_DWELL) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_DWELL - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYC - 1);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_idx;
    logic [23:0]          r_act_data;
    logic [5:0]           r_act_dp;
    logic [23:0]          r_pend_data;
    logic [5:0]           r_pend_dp;
    logic                 r_pend;
    logic                 r_frame_start;
    logic [5:0]           r_sel;
    logic [7:0]           r_seg;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic [3:0]           w_nib;
    logic                 w_dp;
    logic                 w_lz;
    logic [5:0]           w_sel_nxt;
    logic [7:0]           w_seg_nxt;
    logic                 w_fs_nxt;

    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_slot_end    = (r_cnt == c_CNT_LAST);
    assign w_frame_end   = w_slot_end && (r_idx == 3'd5);
    assign upd.upd_ready = ~r_pend;
    assign frame_start   = r_frame_start;
    assign sel           = r_sel;
    assign seg           = r_seg;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GUARD: if (r_cnt == c_BLANK_LAST) w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_slot_end)            w_state_nxt = ST_GUARD;
            default:                             w_state_nxt = ST_GUARD;
        endcase
    end

    // Output values for the current cnt/idx; registered below for one cycle of latency.
    always_comb begin
        w_nib     = 4'h0;
        w_dp      = 1'b0;
        w_lz      = 1'b0;
        w_sel_nxt = 6'h3F;
        w_seg_nxt = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            if (r_idx == 3'(i)) begin
                w_nib = r_act_data[4*i +: 4];
                w_dp  = r_act_dp[i];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < 6; i++) begin
            if ((r_idx == 3'(i)) && ((r_act_data >> (4*i)) == 24'h0)) w_lz = 1'b1;
        end
`endif
        if (r_state == ST_SHOW) begin
            if (en) w_sel_nxt = ~(6'b1 << r_idx);
            w_seg_nxt = {~w_dp, (w_lz ? 7'h7F : f_hex_to_seg(w_nib))};
        end
        w_fs_nxt = (r_cnt == '0) && (r_idx == 3'd0);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= ST_GUARD;
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_act_data    <= 24'h0;
            r_act_dp      <= 6'h0;
            r_pend_data   <= 24'h0;
            r_pend_dp     <= 6'h0;
            r_pend        <= 1'b0;
            r_frame_start <= 1'b0;
            r_sel         <= 6'h3F;
            r_seg         <= 8'hFF;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_slot_end ? '0 : r_cnt + c_CNT_W'(1);
            if (w_slot_end) r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            // Accept and transfer never coincide: ready is low whenever pend is set.
            if (w_frame_end && r_pend) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_pend     <= 1'b0;
            end else if (upd.upd_valid && !r_pend) begin
                r_pend_data <= upd.upd_data;
                r_pend_dp   <= upd.upd_dp;
                r_pend      <= 1'b1;
            end
            r_frame_start <= w_fs_nxt;
            r_sel         <= w_sel_nxt;
            r_seg         <= w_seg_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (DWELL=6, BLANK_CYC=1)
//               against a frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_BLANK = 1;
    localparam int c_DWELL = 6;
    localparam int c_FRAME = 6 * c_DWELL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       frame_start;
    logic [5:0] sel;
    logic [7:0] seg;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .CLK_FREQ  (60),
        .SCAN_FREQ (10),
        .BLANK_CYC (c_BLANK)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .en          (en),
        .upd         (bus),
        .frame_start (frame_start),
        .sel         (sel),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    int n_check = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        n_check++;
        $display("FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    // Reference model: the display position is simply elapsed cycles mod frame.
    logic [7:0]  dec_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int unsigned tick;
    int          m_pos, m_slot, m_c;
    logic [23:0] m_act, m_pdata;
    logic [5:0]  m_act_dp, m_pdp;
    logic        m_pend;
    logic [5:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_fs, e_rdy;
    bit          e_ok = 1'b0;

    function automatic logic [7:0] exp_digit(input logic [23:0] d, input logic [5:0] dp, input int s);
        logic [7:0] r;
        logic [3:0] n;
        n = d[4*s +: 4];
        r = {~dp[s], dec_tbl[n][6:0]};
`ifdef LEADING_ZERO_BLANK_EN
        if (s >= 1 && (d >> (4*s)) == 24'h0) r[6:0] = 7'h7F;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            tick     = 0;
            m_pend   = 1'b0;
            m_act    = 24'h0;
            m_act_dp = 6'h0;
            e_sel    = 6'h3F;
            e_seg    = 8'hFF;
            e_fs     = 1'b0;
        end else begin
            m_pos  = int'(tick % c_FRAME);
            m_slot = m_pos / c_DWELL;
            m_c    = m_pos % c_DWELL;
            e_fs   = (m_pos == 0);
            e_sel  = (m_c < c_BLANK || !en) ? 6'h3F : ~(6'd1 << m_slot);
            e_seg  = (m_c < c_BLANK) ? 8'hFF : exp_digit(m_act, m_act_dp, m_slot);
            if (m_pos == c_FRAME - 1 && m_pend) begin
                m_act    = m_pdata;
                m_act_dp = m_pdp;
                m_pend   = 1'b0;
            end else if (bus.upd_valid && !m_pend) begin
                m_pdata = bus.upd_data;
                m_pdp   = bus.upd_dp;
                m_pend  = 1'b1;
            end
            tick++;
        end
        e_rdy = !m_pend;
        e_ok  = 1'b1;
    end

    always @(negedge clk) begin
        if (e_ok) begin
            chk("model_sel", 32'(sel), 32'(e_sel));
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_frame_start", 32'(frame_start), 32'(e_fs));
            chk("model_upd_ready", 32'(bus.upd_ready), 32'(e_rdy));
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [23:0] d, input logic [5:0] p);
        int k;
        k = 0;
        while (bus.upd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_timeout("send_ready");
        bus.upd_valid = 1'b1;
        bus.upd_data  = d;
        bus.upd_dp    = p;
        @(negedge clk);
        bus.upd_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 100);
        if (frame_start !== 1'b1) fail_timeout("wait_frame_start");
    endtask

    logic [23:0] mask;

    initial begin
        bus.upd_valid = 1'b0;
        bus.upd_data  = 24'h0;
        bus.upd_dp    = 6'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_sel", 32'(sel), 32'h3F);
            chk("rst_seg", 32'(seg), 32'hFF);
            chk("rst_ready", 32'(bus.upd_ready), 32'h1);
        end
        rst = 1'b0;
        adv(1);
        chk("first_fs", 32'(frame_start), 32'h1);
        chk("first_fs_sel", 32'(sel), 32'h3F);
        adv(c_FRAME);
        chk("fs_period", 32'(frame_start), 32'h1);

        // Scan order
        send(24'h543210, 6'b000001);
        wait_fs();
        adv(1);  chk("d0_sel", 32'(sel), 32'h3E); chk("d0_seg", 32'(seg), 32'h40);
        adv(6);  chk("d1_sel", 32'(sel), 32'h3D); chk("d1_seg", 32'(seg), 32'hF9);
        adv(6);  chk("d2_sel", 32'(sel), 32'h3B); chk("d2_seg", 32'(seg), 32'hA4);
        adv(1);
        // Tear-free: update mid-frame, digit 5 still shows the old value
        send(24'hFFFFFF, 6'h00);
        chk("tear_ready_low", 32'(bus.upd_ready), 32'h0);
        adv(16); chk("d5_sel", 32'(sel), 32'h1F); chk("d5_seg_old", 32'(seg), 32'h92);

        // Back-pressure
        bus.upd_valid = 1'b1;
        bus.upd_data  = 24'h000001;
        bus.upd_dp    = 6'h00;
        adv(1);
        chk("bp_ready_low", 32'(bus.upd_ready), 32'h0);
        begin
            int k;
            k = 0;
            while (bus.upd_ready !== 1'b1 && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) fail_timeout("bp_ready");
        end
        adv(1);
        chk("bp_boundary_fs", 32'(frame_start), 32'h1);
        chk("bp_accepted", 32'(bus.upd_ready), 32'h0);
        bus.upd_valid = 1'b0;
        adv(1);  chk("ff_sel", 32'(sel), 32'h3E); chk("ff_seg", 32'(seg), 32'h8E);
        wait_fs();
        adv(1);  chk("one_seg", 32'(seg), 32'hF9);
        adv(30); chk("one_d5_sel", 32'(sel), 32'h1F);
`ifdef LEADING_ZERO_BLANK_EN
        chk("one_d5_seg", 32'(seg), 32'hFF);
`else
        chk("one_d5_seg", 32'(seg), 32'hC0);
`endif

        // Enable drop during digit 3
        wait_fs();
        adv(19); chk("en_d3_sel", 32'(sel), 32'h37);
        en = 1'b0;
        adv(1);  chk("en_off_sel", 32'(sel), 32'h3F);
        adv(3);  en = 1'b1;
        adv(1);

        // Leading-zero case
        send(24'h000120, 6'h00);
        wait_fs();
        adv(1);  chk("lz_d0_seg", 32'(seg), 32'hC0);
        adv(12); chk("lz_d2_seg", 32'(seg), 32'hF9);
        adv(6);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d3_seg", 32'(seg), 32'hFF);
`else
        chk("lz_d3_seg", 32'(seg), 32'hC0);
`endif

        // Reset mid-slot discards a pending update
        send(24'hABCDEF, 6'h3F);
        adv(2);
        rst = 1'b1;
        adv(1);
        chk("mid_rst_sel", 32'(sel), 32'h3F);
        chk("mid_rst_seg", 32'(seg), 32'hFF);
        chk("mid_rst_ready", 32'(bus.upd_ready), 32'h1);
        chk("mid_rst_fs", 32'(frame_start), 32'h0);
        adv(1);
        rst = 1'b0;
        adv(1);
        chk("post_rst_fs", 32'(frame_start), 32'h1);
        adv(c_FRAME + 1);
        chk("post_rst_d0", 32'(seg), 32'hC0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 299) == 0);
            en            = ($urandom_range(0, 7) != 0);
            mask          = 24'hFFFFFF >> (4 * $urandom_range(0, 6));
            bus.upd_valid = ($urandom_range(0, 3) == 0);
            bus.upd_data  = 24'($urandom) & mask;
            bus.upd_dp    = 6'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.upd_valid = 1'b0;
        adv(2);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
